// File: rtl/arith_pkg.sv
// Shared types and 7-seg constants for seq_arith_unit.
// Segment patterns are active-high {dp,g,f,e,d,c,b,a}.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULU = 2'b10,
    OP_MULS = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [7:0] ZERO_SEG  = 8'h3F;
  localparam logic [7:0] ONE_SEG   = 8'h06;
  localparam logic [7:0] TWO_SEG   = 8'h5B;
  localparam logic [7:0] THREE_SEG = 8'h4F;
  localparam logic [7:0] FOUR_SEG  = 8'h66;
  localparam logic [7:0] FIVE_SEG  = 8'h6D;
  localparam logic [7:0] SIX_SEG   = 8'h7D;
  localparam logic [7:0] SEVEN_SEG = 8'h07;
  localparam logic [7:0] EIGHT_SEG = 8'h7F;
  localparam logic [7:0] NINE_SEG  = 8'h6F;
  localparam logic [7:0] ERR_SEG   = 8'h79;
  localparam logic [7:0] NEG_DP    = 8'h80;

  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = ZERO_SEG;
      4'd1:    digit_seg = ONE_SEG;
      4'd2:    digit_seg = TWO_SEG;
      4'd3:    digit_seg = THREE_SEG;
      4'd4:    digit_seg = FOUR_SEG;
      4'd5:    digit_seg = FIVE_SEG;
      4'd6:    digit_seg = SIX_SEG;
      4'd7:    digit_seg = SEVEN_SEG;
      4'd8:    digit_seg = EIGHT_SEG;
      4'd9:    digit_seg = NINE_SEG;
      default: digit_seg = ERR_SEG;
    endcase
  endfunction

endpackage

// File: rtl/seg7_signed_digit.sv
// Single signed decimal digit decoder: |value| <= 9 shows the digit,
// DP marks a negative value, anything larger shows ERR_SEG.
module seg7_signed_digit
  import arith_pkg::*;
#(
  parameter int W         = 6,
  parameter int NBITS_SEG = 8
) (
  input  logic [W-1:0]         value,
  input  logic                 is_signed,
  output logic [NBITS_SEG-1:0] seg
);

  logic         neg;
  logic [W-1:0] mag;
  logic [7:0]   pat;

  always_comb begin
    neg = is_signed & value[W-1];
    mag = neg ? -value : value;
    pat = ERR_SEG;
    if (mag <= W'(9))
      pat = digit_seg(mag[3:0]) | (neg ? NEG_DP : 8'h00);
    seg = NBITS_SEG'(pat);
  end

endmodule

// File: rtl/seq_arith_unit.sv
// ADD/SUB in one cycle, MULU/MULS by iterative shift-add.
// Define SEQ_ARITH_SEG_EN to build the 7-seg digit decoder.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int NBITS     = 3,
  parameter int NBITS_SEG = 8
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [NBITS-1:0]     a,
  input  logic [NBITS-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*NBITS-1:0]   result,
  output logic                 overflow,
  output logic [NBITS_SEG-1:0] seg
);

  localparam int W  = 2 * NBITS;
  localparam int CW = $clog2(NBITS + 1);

  state_t           state;
  op_t              op_q;
  logic [W-1:0]     mcand;
  logic [W-1:0]     acc;
  logic [NBITS-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             is_sub;
  logic             is_muls;
  logic [NBITS-1:0] bb;
  logic [NBITS-1:0] sum;
  logic             as_ovf;
  logic [NBITS-1:0] mag_a;
  logic [NBITS-1:0] mag_b;
  logic [W-1:0]     prod;
  logic [W-1:0]     mres;
  logic [NBITS:0]   mtop;
  logic             movf;

  always_comb begin
    is_sub  = (op == OP_SUB);
    is_muls = (op == OP_MULS);
    bb      = is_sub ? ~b : b;
    sum     = a + bb + NBITS'(is_sub);
    as_ovf  = (a[NBITS-1] == bb[NBITS-1]) &&
              (sum[NBITS-1] != a[NBITS-1]);
    mag_a   = (is_muls && a[NBITS-1]) ? -a : a;
    mag_b   = (is_muls && b[NBITS-1]) ? -b : b;
    // Final iteration folds in the last partial product directly
    prod    = acc + (mplier[0] ? mcand : '0);
    mres    = neg ? -prod : prod;
    mtop    = mres[W-1:NBITS-1];
    if (op_q == OP_MULS)
      movf = !(&mtop || !(|mtop));
    else
      movf = |mres[W-1:NBITS];
  end

`ifdef SEQ_ARITH_SEG_EN
  logic res_signed;
`endif

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
`ifdef SEQ_ARITH_SEG_EN
      res_signed <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            busy <= 1'b1;
            if (!op[1]) begin
              result   <= {{NBITS{sum[NBITS-1]}}, sum};
              overflow <= as_ovf;
              done     <= 1'b1;
              state    <= S_DONE;
`ifdef SEQ_ARITH_SEG_EN
              res_signed <= 1'b1;
`endif
            end else begin
              mcand  <= W'(mag_a);
              mplier <= mag_b;
              acc    <= '0;
              cnt    <= '0;
              neg    <= is_muls && (a[NBITS-1] ^ b[NBITS-1]);
              state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc    <= prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(NBITS - 1)) begin
            result   <= mres;
            overflow <= movf;
            done     <= 1'b1;
            state    <= S_DONE;
`ifdef SEQ_ARITH_SEG_EN
            res_signed <= (op_q == OP_MULS);
`endif
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_ARITH_SEG_EN
  seg7_signed_digit #(
    .W         (W),
    .NBITS_SEG (NBITS_SEG)
  ) u_seg (
    .value     (result),
    .is_signed (res_signed),
    .seg       (seg)
  );
`else
  assign seg = '0;
`endif

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit: directed cases, start injection,
// mid-multiply reset and random ops against an integer model.
module tb_seq_arith_unit;

  localparam int N    = 3;
  localparam int W    = 2 * N;
  localparam int SEGW = 8;

  logic            clk_2 = 1'b0;
  logic            reset;
  logic            start;
  logic [1:0]      op;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            busy;
  logic            done;
  logic [W-1:0]    result;
  logic            overflow;
  logic [SEGW-1:0] seg;

  int tests = 0;
  int fails = 0;

  logic [7:0] digits [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  always #5 clk_2 = ~clk_2;

  seq_arith_unit #(.NBITS(N), .NBITS_SEG(SEGW)) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .seg      (seg)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic logic [SEGW-1:0] exp_seg(input int disp);
    logic [SEGW-1:0] s;
    int mag;
    mag = (disp < 0) ? -disp : disp;
    if (mag <= 9)
      s = digits[mag] | ((disp < 0) ? 8'h80 : 8'h00);
    else
      s = 8'h79;
`ifndef SEQ_ARITH_SEG_EN
    s = '0;
`endif
    return s;
  endfunction

  task automatic model(input int o, input int ai, input int bi,
                       output logic [W-1:0] r, output logic ov,
                       output logic [SEGW-1:0] sg);
    int sa, sb, v, lo, hi, disp;
    sa = sx(ai, N);
    sb = sx(bi, N);
    lo = -(1 << (N - 1));
    hi = (1 << (N - 1)) - 1;
    case (o)
      0, 1: begin
        v  = (o == 0) ? sa + sb : sa - sb;
        ov = (v < lo) || (v > hi);
        r  = W'(sx(v & ((1 << N) - 1), N));
      end
      2: begin
        v  = ai * bi;
        ov = v > (1 << N) - 1;
        r  = W'(v);
      end
      default: begin
        v  = sa * sb;
        ov = (v < lo) || (v > hi);
        r  = W'(v);
      end
    endcase
    disp = (o == 2) ? int'(r) : sx(int'(r), W);
    sg = exp_seg(disp);
  endtask

  task automatic run(input int o, input int ai, input int bi,
                     input bit inject);
    logic [W-1:0]    er;
    logic            eo;
    logic [SEGW-1:0] es;
    int lat, busyc, explat;
    bit got;
    model(o, ai, bi, er, eo, es);
    explat = (o < 2) ? 1 : N + 1;
    @(negedge clk_2);
    start = 1'b1;
    op    = 2'(o);
    a     = N'(ai);
    b     = N'(bi);
    lat   = 0;
    busyc = 0;
    got   = 0;
    while (!got && lat < 20) begin
      @(posedge clk_2);
      #1;
      lat++;
      if (busy) busyc++;
      if (done) got = 1;
      start = inject;
      op    = inject ? 2'($urandom) : 2'(o);
      a     = N'($urandom);
      b     = N'($urandom);
    end
    check("latency", lat, explat);
    check("busy_cycles", busyc, explat);
    check("result", 32'(result), 32'(er));
    check("overflow", 32'(overflow), 32'(eo));
    check("seg", 32'(seg), 32'(es));
    @(posedge clk_2);
    #1;
    start = 1'b0;
    check("after_done", {30'd0, busy, done}, 32'd0);
    check("held_result", 32'(result), 32'(er));
  endtask

  initial begin
    logic [SEGW-1:0] zs;
    bit seen;
    zs = exp_seg(0);
    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_seg", 32'(seg), 32'(zs));
    @(negedge clk_2);
    reset = 1'b0;

    run(0, 3, 1, 0);
    run(1, 4, 1, 0);
    run(1, 7, 4, 0);
    run(2, 7, 7, 0);
    run(3, 4, 4, 0);
    run(3, 7, 3, 0);
    run(2, 5, 6, 1);
    run(3, 6, 5, 1);
    run(0, 2, 3, 1);

    @(negedge clk_2);
    start = 1'b1;
    op    = 2'd2;
    a     = 3'd7;
    b     = 3'd7;
    @(posedge clk_2);
    #1;
    start = 1'b0;
    @(posedge clk_2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_seg", 32'(seg), 32'(zs));
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk_2);
      #1;
      if (done || busy) seen = 1;
    end
    check("no_done_after_rst", 32'(seen), 32'd0);
    run(3, 4, 7, 0);

    repeat (40) begin
      run(int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
          int'($urandom_range(7, 0)), bit'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
